bcp_priority_scheduler: RTL and testbench

- Parametrised, sequential successor to the combinational 8-bit priority encoder used in hardware BCP.
- Captures a WIDTH-bit vector of pending implications or assignments from the clause units.
- Emits the index of each set bit one per handshake, highest priority first, clearing each bit as it is issued.
- Signals completion so the assignment FSM can sequence propagation without re-encoding the vector.

---
 rtl/bcp_priority_scheduler.sv | 128 ++++++++++++
 tb/tb_bcp_priority_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcp_priority_scheduler.sv
// Sequential priority scheduler for BCP: captures a request vector and issues one set-bit index
// per handshake, highest first. Optional macro BCP_SCHED_ROUND_ROBIN_EN enables rotating priority.
module bcp_priority_scheduler #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_remaining,
  output logic             done
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] pend_cnt;
  logic             issue;

  assign issue = (state_q == StBusy) && out_ready && !flush;

`ifdef BCP_SCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;

  // Scan downward from ptr-1 (mod WIDTH); ptr=0 starts the scan at the top bit.
  always_comb begin : sel_rr
    int unsigned pos;
    logic        found;
    sel_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      pos = (32'(ptr_q) + WIDTH - k) % WIDTH;
      if (!found && pend_q[pos[IDX_W-1:0]]) begin
        sel_idx = pos[IDX_W-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (issue) begin
      ptr_q <= sel_idx;
    end
  end
`else
  always_comb begin : sel_fixed
    sel_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend_q[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin : popcount
    pend_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pend_cnt = pend_cnt + CNT_W'(pend_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    pend_d  = pend_q;
    if (flush) begin
      state_d = StIdle;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            pend_d  = in_vec;
            state_d = (in_vec != '0) ? StBusy : StDone;
          end
        end
        StBusy: begin
          if (out_ready) begin
            pend_d[sel_idx] = 1'b0;
            if (pend_cnt == CNT_W'(1)) begin
              state_d = StDone;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin : outputs
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    done          = 1'b0;
    out_idx       = sel_idx;
    out_remaining = pend_cnt;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StBusy:  out_valid = 1'b1;
      StDone:  done      = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bcp_priority_scheduler.sv
// Self-checking bench for bcp_priority_scheduler (WIDTH=8): directed vector table, a round-robin
// ordering sequence, and randomized traffic against a queue-level reference model.
module tb_bcp_priority_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_vec = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [3:0] out_remaining;
  logic       done;

  bcp_priority_scheduler #(.WIDTH(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vec        (in_vec),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .out_remaining (out_remaining),
    .done          (done)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit       r;
    bit       iv;
    bit [7:0] v;
    bit       f;
    bit       o;
    bit       ir;
    bit       ov;
    int       idx;
    int       rem;
    bit       d;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input bit ir, input bit ov, input int idx,
                            input int rem, input bit d);
    check({tag, ".in_ready"}, int'(in_ready), int'(ir));
    check({tag, ".out_valid"}, int'(out_valid), int'(ov));
    check({tag, ".out_idx"}, int'(out_idx), idx);
    check({tag, ".out_remaining"}, int'(out_remaining), rem);
    check({tag, ".done"}, int'(done), int'(d));
  endtask

  task automatic drive(input bit r, input bit iv, input bit [7:0] v, input bit f, input bit o);
    reset_n   = r;
    in_valid  = iv;
    in_vec    = v;
    flush     = f;
    out_ready = o;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void add(input bit r, input bit iv, input bit [7:0] v, input bit f,
                              input bit o, input bit ir, input bit ov, input int idx,
                              input int rem, input bit d);
    vec_t e;
    e = '{r, iv, v, f, o, ir, ov, idx, rem, d};
    tbl.push_back(e);
  endfunction

  // Reference model: pending set, phase (0 idle, 1 busy, 2 done) and rotating pointer.
  bit [7:0] m_pend;
  int       m_phase;
  int       m_ptr;

  function automatic int m_pick();
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (m_ptr - k + 16) % 8;
      if (m_pend[j]) return j;
    end
    return 0;
  endfunction

  function automatic void m_step(input bit r, input bit iv, input bit [7:0] v, input bit f,
                                 input bit o);
    int i;
    if (!r) begin
      m_pend = 8'h00; m_phase = 0; m_ptr = 0;
    end else if (f) begin
      m_pend = 8'h00; m_phase = 0;
    end else if (m_phase == 0) begin
      if (iv) begin
        m_pend  = v;
        m_phase = (v != 0) ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (o) begin
        i = m_pick();
        m_pend[i] = 1'b0;
`ifdef BCP_SCHED_ROUND_ROBIN_EN
        m_ptr = i;
`endif
        if (m_pend == 0) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  int exp_rr[3];

  initial begin
    // r iv vec f o | ir ov idx rem done
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);   // reset held two cycles
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 8'hA5, 0, 1, 0, 1, 7, 4, 0);   // basic drain
    add(1, 0, 8'h00, 0, 1, 0, 1, 5, 3, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 2, 2, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);   // backpressure
    add(1, 1, 8'h12, 0, 0, 0, 1, 4, 2, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 4, 2, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 4, 2, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 4, 2, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 1);   // empty load
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);   // load while busy is ignored
    add(1, 1, 8'h03, 0, 0, 0, 1, 1, 2, 0);
    add(1, 1, 8'hF0, 0, 1, 0, 1, 0, 1, 0);
    add(1, 1, 8'hF0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);   // flush mid-drain
    add(1, 1, 8'hFF, 0, 0, 0, 1, 7, 8, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 6, 7, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 5, 6, 0);
    add(1, 1, 8'h0F, 1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);   // reset mid-drain
    add(1, 1, 8'hFF, 0, 0, 0, 1, 7, 8, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 6, 7, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 5, 6, 0);
    add(0, 1, 8'h0F, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);

    #1;
    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].iv, tbl[n].v, tbl[n].f, tbl[n].o);
      tick();
      check_outs($sformatf("vec%0d", n), tbl[n].ir, tbl[n].ov, tbl[n].idx, tbl[n].rem, tbl[n].d);
    end

    // Priority order after a flush that leaves the pointer at 6.
`ifdef BCP_SCHED_ROUND_ROBIN_EN
    exp_rr = '{0, 7, 6};
`else
    exp_rr = '{7, 6, 0};
`endif
    drive(0, 0, 8'h00, 0, 0); tick();
    drive(1, 1, 8'hFF, 0, 0); tick();
    check("rr.first", int'(out_idx), 7);
    drive(1, 0, 8'h00, 0, 1); tick();
    check("rr.second", int'(out_idx), 6);
    tick();
    drive(1, 0, 8'h00, 1, 1); tick();
    check("rr.flushed", int'(out_valid), 0);
    drive(1, 1, 8'hC1, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rr.order%0d", k), int'(out_idx), exp_rr[k]);
      drive(1, 0, 8'h00, 0, 1); tick();
    end
    check("rr.done", int'(done), 1);

    // Randomized traffic against the reference model.
    m_pend = 8'h00; m_phase = 0; m_ptr = 0;
    for (int c = 0; c < 2000; c++) begin
      bit       r, iv, f, o;
      bit [7:0] v;
      r  = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      f  = ($urandom_range(0, 24) == 0);
      iv = $urandom_range(0, 1) == 1;
      v  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      o  = ($urandom_range(0, 2) != 0);
      drive(r, iv, v, f, o);
      tick();
      m_step(r, iv, v, f, o);
      check_outs($sformatf("rnd%0d", c), m_phase == 0, m_phase == 1,
                 (m_pend != 0) ? m_pick() : 0, $countones(m_pend), m_phase == 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
